// File: rtl/sysio_hub.sv
// AXI4-Lite slave hub for the system I/O region: slot decode, write holding
// registers with B channel, registered read path, DECERR for empty slots.
module sysio_hub #(
    parameter int unsigned N_SLOT    = 16,
    parameter int unsigned SLOT_AW   = 8,
    parameter int unsigned SEL_LSB   = 8,
    parameter logic [31:0] SLOT_MASK = 32'h0000_801F,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                s_awaddr,
    input  logic                       s_awvalid,
    output logic                       s_awready,
    input  logic [DATA_W-1:0]          s_wdata,
    input  logic [DATA_W/8-1:0]        s_wstrb,
    input  logic                       s_wvalid,
    output logic                       s_wready,
    output logic [1:0]                 s_bresp,
    output logic                       s_bvalid,
    input  logic                       s_bready,
    input  logic [31:0]                s_araddr,
    input  logic                       s_arvalid,
    output logic                       s_arready,
    output logic [DATA_W-1:0]          s_rdata,
    output logic [1:0]                 s_rresp,
    output logic                       s_rvalid,
    input  logic                       s_rready,
    output logic [SLOT_AW-1:0]         p_waddr,
    output logic [DATA_W-1:0]          p_wdata,
    output logic [DATA_W/8-1:0]        p_sel,
    output logic [N_SLOT-1:0]          p_we,
    output logic [SLOT_AW-1:0]         p_raddr,
    output logic [N_SLOT-1:0]          p_rd,
    input  logic [N_SLOT*DATA_W-1:0]   p_rdata
);

    localparam int unsigned SEL_W  = $clog2(N_SLOT);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [N_SLOT-1:0] ONE = N_SLOT'(1);

    typedef enum logic [1:0] {R_IDLE, R_CAP, R_RESP} rstate_e;

    function automatic logic populated(input logic [SEL_W-1:0] s);
        return SLOT_MASK[s];
    endfunction

    function automatic logic [SLOT_AW-1:0] word_addr(input logic [31:0] a);
        return {a[SLOT_AW-1:2], 2'b00};
    endfunction

    // Upper address bits are pre-decoded by the interconnect.
    logic unused_addr;
    assign unused_addr = ^{s_awaddr, s_araddr};

    logic                aw_held_q, aw_held_d;
    logic                w_held_q, w_held_d;
    logic [SEL_W-1:0]    wslot_q, wslot_d;
    logic [SLOT_AW-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                aw_hs, w_hs, commit;

    assign s_awready = ~rst & ~aw_held_q;
    assign s_wready  = ~rst & ~w_held_q;
    assign aw_hs     = s_awvalid & s_awready;
    assign w_hs      = s_wvalid & s_wready;
    assign commit    = aw_held_q & w_held_q & ~bvalid_q;

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        wslot_d   = wslot_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            wslot_d   = s_awaddr[SEL_LSB +: SEL_W];
            waddr_d   = word_addr(s_awaddr);
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_wdata;
            wstrb_d  = s_wstrb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = populated(wslot_q) ? 2'b00 : 2'b11;
        end else if (bvalid_q && s_bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            wslot_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            wslot_q   <= wslot_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign p_waddr  = waddr_q;
    assign p_wdata  = wdata_q;
    assign p_sel    = wstrb_q;
    assign p_we     = (commit && populated(wslot_q)) ? (ONE << wslot_q) : '0;
    assign s_bvalid = bvalid_q;
    assign s_bresp  = bresp_q;

    rstate_e             state_q, state_d;
    logic [SEL_W-1:0]    rslot_q, rslot_d;
    logic                rdec_q, rdec_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rvalid_q, rvalid_d;
    logic                ar_hs;
    logic [SEL_W-1:0]    ar_slot;

    assign s_arready = ~rst & ((state_q == R_IDLE) ||
                               ((state_q == R_RESP) && s_rready));
    assign ar_hs     = s_arvalid & s_arready;
    assign ar_slot   = s_araddr[SEL_LSB +: SEL_W];
    assign p_rd      = (ar_hs && populated(ar_slot)) ? (ONE << ar_slot) : '0;
    assign p_raddr   = ar_hs ? word_addr(s_araddr) : '0;

    always_comb begin
        state_d  = state_q;
        rslot_d  = rslot_q;
        rdec_d   = rdec_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rvalid_d = rvalid_q;
        unique case (state_q)
            R_IDLE: ;
            R_CAP: begin
                rdata_d  = rdec_q ? '0 : p_rdata[rslot_q*DATA_W +: DATA_W];
                rresp_d  = rdec_q ? 2'b11 : 2'b00;
                rvalid_d = 1'b1;
                state_d  = R_RESP;
            end
            R_RESP: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
        // An AR taken in the R beat's handshake cycle skips R_IDLE.
        if (ar_hs) begin
            state_d = R_CAP;
            rslot_d = ar_slot;
            rdec_d  = ~populated(ar_slot);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= R_IDLE;
            rslot_q  <= '0;
            rdec_q   <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rslot_q  <= rslot_d;
            rdec_q   <= rdec_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;
    assign s_rvalid = rvalid_q;

endmodule

// File: tb/tb_sysio_hub.sv
// Directed testbench for sysio_hub: write/read paths, DECERR, back-to-back
// traffic and asynchronous reset in the middle of transactions.
module tb_sysio_hub;

    logic           clk;
    logic           rst;
    logic [31:0]    s_awaddr;
    logic           s_awvalid;
    logic           s_awready;
    logic [31:0]    s_wdata;
    logic [3:0]     s_wstrb;
    logic           s_wvalid;
    logic           s_wready;
    logic [1:0]     s_bresp;
    logic           s_bvalid;
    logic           s_bready;
    logic [31:0]    s_araddr;
    logic           s_arvalid;
    logic           s_arready;
    logic [31:0]    s_rdata;
    logic [1:0]     s_rresp;
    logic           s_rvalid;
    logic           s_rready;
    logic [7:0]     p_waddr;
    logic [31:0]    p_wdata;
    logic [3:0]     p_sel;
    logic [15:0]    p_we;
    logic [7:0]     p_raddr;
    logic [15:0]    p_rd;
    logic [511:0]   p_rdata;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int rd_cnt = 0;

    sysio_hub dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .p_waddr(p_waddr), .p_wdata(p_wdata), .p_sel(p_sel), .p_we(p_we),
        .p_raddr(p_raddr), .p_rd(p_rd), .p_rdata(p_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts pulses and flags any multi-hot strobe.
    always @(posedge clk) begin
        #3;
        if (p_we != '0) begin
            we_cnt++;
            checks++;
            if ($countones(p_we) != 1) begin
                errors++;
                $display("FAIL p_we_onehot: got %h want one-hot", p_we);
            end
        end
        if (p_rd != '0) begin
            rd_cnt++;
            checks++;
            if ($countones(p_rd) != 1) begin
                errors++;
                $display("FAIL p_rd_onehot: got %h want one-hot", p_rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        #4;
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b want 00000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        checks++;
        if ({p_we, p_rd, s_rdata, p_waddr, p_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got we=%h rd=%h rdata=%h want 0",
                     p_we, p_rd, s_rdata);
        end
        tick();
        rst = 1'b0;
        #4;
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release: got %b want 111",
                     {s_awready, s_wready, s_arready});
        end
    endtask

    task automatic test_aw_first();
        tick();
        we_cnt = 0;
        s_awaddr = 32'h0000_0408;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        #4;
        checks++;
        if (s_awready !== 1'b0) begin
            errors++;
            $display("FAIL awf_held: got awready=%b want 0", s_awready);
        end
        tick();
        tick();
        s_wdata = 32'hDEAD_BEEF;
        s_wstrb = 4'hF;
        s_wvalid = 1'b1;
        #4;
        checks++;
        if (p_we !== 16'h0) begin
            errors++;
            $display("FAIL awf_early_we: got %h want 0000", p_we);
        end
        tick();
        s_wvalid = 1'b0;
        #4;
        checks++;
        if (p_we !== 16'h0010 || p_waddr !== 8'h08 ||
            p_wdata !== 32'hDEAD_BEEF || p_sel !== 4'hF) begin
            errors++;
            $display("FAIL awf_commit: got we=%h a=%h d=%h s=%h want 0010 08 deadbeef f",
                     p_we, p_waddr, p_wdata, p_sel);
        end
        checks++;
        if (s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL awf_b_early: got %b want 0", s_bvalid);
        end
        tick();
        s_bready = 1'b1;
        #4;
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
            errors++;
            $display("FAIL awf_b: got v=%b r=%b want 1 00", s_bvalid, s_bresp);
        end
        tick();
        s_bready = 1'b0;
        #4;
        checks++;
        if (s_bvalid !== 1'b0 || we_cnt !== 1) begin
            errors++;
            $display("FAIL awf_done: got bvalid=%b pulses=%0d want 0 1",
                     s_bvalid, we_cnt);
        end
    endtask

    task automatic test_w_first_bstall();
        tick();
        we_cnt = 0;
        s_wdata = 32'h1111_1111;
        s_wstrb = 4'h3;
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        s_awaddr = 32'h0000_0010;
        s_awvalid = 1'b1;
        #4;
        checks++;
        if (s_wready !== 1'b0 || p_we !== 16'h0) begin
            errors++;
            $display("FAIL wf_held: got wready=%b we=%h want 0 0000", s_wready, p_we);
        end
        tick();
        s_awvalid = 1'b0;
        #4;
        checks++;
        if (p_we !== 16'h0001 || p_waddr !== 8'h10 ||
            p_wdata !== 32'h1111_1111 || p_sel !== 4'h3) begin
            errors++;
            $display("FAIL wf_commit1: got we=%h a=%h d=%h s=%h want 0001 10 11111111 3",
                     p_we, p_waddr, p_wdata, p_sel);
        end
        tick();
        s_awaddr = 32'h0000_0104;
        s_awvalid = 1'b1;
        s_wdata = 32'h2222_2222;
        s_wstrb = 4'hF;
        s_wvalid = 1'b1;
        #4;
        checks++;
        if (s_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL wf_b1: got %b want 1", s_bvalid);
        end
        for (int c = 4; c < 8; c++) begin
            tick();
            s_awvalid = 1'b0;
            s_wvalid = 1'b0;
            #4;
            checks++;
            if (p_we !== 16'h0) begin
                errors++;
                $display("FAIL wf_stall_we: got %h want 0000 (cycle %0d)", p_we, c);
            end
        end
        tick();
        s_bready = 1'b1;
        #4;
        checks++;
        if (p_we !== 16'h0 || we_cnt !== 1) begin
            errors++;
            $display("FAIL wf_stall_end: got we=%h pulses=%0d want 0000 1", p_we, we_cnt);
        end
        tick();
        s_bready = 1'b0;
        #4;
        checks++;
        if (p_we !== 16'h0002 || p_waddr !== 8'h04 || p_wdata !== 32'h2222_2222) begin
            errors++;
            $display("FAIL wf_commit2: got we=%h a=%h d=%h want 0002 04 22222222",
                     p_we, p_waddr, p_wdata);
        end
        tick();
        s_bready = 1'b1;
        #4;
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
            errors++;
            $display("FAIL wf_b2: got v=%b r=%b want 1 00", s_bvalid, s_bresp);
        end
        tick();
        s_bready = 1'b0;
        #4;
        checks++;
        if (we_cnt !== 2 || s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wf_count: got pulses=%0d bvalid=%b want 2 0", we_cnt, s_bvalid);
        end
    endtask

    task automatic test_read_slot15();
        tick();
        rd_cnt = 0;
        p_rdata[15*32 +: 32] = 32'h1234_5678;
        s_araddr = 32'h0000_0F04;
        s_arvalid = 1'b1;
        #4;
        checks++;
        if (p_rd !== 16'h8000 || p_raddr !== 8'h04 || s_arready !== 1'b1) begin
            errors++;
            $display("FAIL rd15_pulse: got rd=%h a=%h ar=%b want 8000 04 1",
                     p_rd, p_raddr, s_arready);
        end
        tick();
        s_arvalid = 1'b0;
        #4;
        checks++;
        if (s_rvalid !== 1'b0 || p_rd !== 16'h0) begin
            errors++;
            $display("FAIL rd15_cap: got rvalid=%b rd=%h want 0 0000", s_rvalid, p_rd);
        end
        tick();
        #4;
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h1234_5678 || s_rresp !== 2'b00) begin
            errors++;
            $display("FAIL rd15_data: got v=%b d=%h r=%b want 1 12345678 00",
                     s_rvalid, s_rdata, s_rresp);
        end
        p_rdata[15*32 +: 32] = 32'hFFFF_0000;
        tick();
        #4;
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd15_hold: got v=%b d=%h want 1 12345678", s_rvalid, s_rdata);
        end
        tick();
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        #4;
        checks++;
        if (s_rvalid !== 1'b0 || rd_cnt !== 1) begin
            errors++;
            $display("FAIL rd15_done: got rvalid=%b pulses=%0d want 0 1", s_rvalid, rd_cnt);
        end
    endtask

    task automatic test_decerr();
        tick();
        we_cnt = 0;
        rd_cnt = 0;
        s_awaddr = 32'h0000_0700;
        s_awvalid = 1'b1;
        s_wdata = 32'h0000_CAFE;
        s_wstrb = 4'hF;
        s_wvalid = 1'b1;
        s_araddr = 32'h0000_0700;
        s_arvalid = 1'b1;
        #4;
        checks++;
        if (p_rd !== 16'h0) begin
            errors++;
            $display("FAIL dec_rd: got %h want 0000", p_rd);
        end
        tick();
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        s_arvalid = 1'b0;
        #4;
        checks++;
        if (p_we !== 16'h0) begin
            errors++;
            $display("FAIL dec_we: got %h want 0000", p_we);
        end
        tick();
        s_bready = 1'b1;
        s_rready = 1'b1;
        #4;
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b11) begin
            errors++;
            $display("FAIL dec_b: got v=%b r=%b want 1 11", s_bvalid, s_bresp);
        end
        checks++;
        if (s_rvalid !== 1'b1 || s_rresp !== 2'b11 || s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL dec_r: got v=%b r=%b d=%h want 1 11 0", s_rvalid, s_rresp, s_rdata);
        end
        tick();
        s_bready = 1'b0;
        s_rready = 1'b0;
        #4;
        checks++;
        if (we_cnt !== 0 || rd_cnt !== 0 || s_bvalid !== 1'b0 || s_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL dec_done: got we=%0d rd=%0d bv=%b rv=%b want 0 0 0 0",
                     we_cnt, rd_cnt, s_bvalid, s_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        logic [15:0] exp_rd;
        logic [15:0] exp_we;
        logic        exp_rv;
        idx = 0;
        s_bready = 1'b1;
        s_rready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            s_awaddr  = 32'h0000_000C;
            s_wdata   = 32'h55AA_55AA;
            s_wstrb   = 4'hF;
            s_awvalid = (c == 0);
            s_wvalid  = (c == 0);
            s_araddr  = 32'(idx) << 8;
            s_arvalid = (idx < 4);
            #4;
            exp_rd = (c % 2 == 0 && c <= 6) ? (16'h0001 << (c / 2)) : 16'h0;
            exp_rv = (c >= 2 && c % 2 == 0);
            exp_we = (c == 1) ? 16'h0001 : 16'h0;
            checks++;
            if (p_rd !== exp_rd) begin
                errors++;
                $display("FAIL b2b_rd: got %h want %h (cycle %0d)", p_rd, exp_rd, c);
            end
            checks++;
            if (s_rvalid !== exp_rv) begin
                errors++;
                $display("FAIL b2b_rvalid: got %b want %b (cycle %0d)", s_rvalid, exp_rv, c);
            end
            if (exp_rv) begin
                checks++;
                if (s_rdata !== 32'hA000_0000 + 32'(c / 2 - 1) || s_rresp !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b_rdata: got %h/%b want %h/00 (cycle %0d)",
                             s_rdata, s_rresp, 32'hA000_0000 + 32'(c / 2 - 1), c);
                end
            end
            checks++;
            if (p_we !== exp_we) begin
                errors++;
                $display("FAIL b2b_we: got %h want %h (cycle %0d)", p_we, exp_we, c);
            end
            if (c == 1) begin
                checks++;
                if (p_waddr !== 8'h0C || p_wdata !== 32'h55AA_55AA) begin
                    errors++;
                    $display("FAIL b2b_wdata: got %h/%h want 0c/55aa55aa", p_waddr, p_wdata);
                end
            end
            if (c == 2) begin
                checks++;
                if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b_b: got v=%b r=%b want 1 00", s_bvalid, s_bresp);
                end
            end
            if (s_arvalid && s_arready) idx++;
        end
        s_arvalid = 1'b0;
        s_bready = 1'b0;
        s_rready = 1'b0;
    endtask

    task automatic test_zero_strb();
        tick();
        s_awaddr = 32'h0000_0104;
        s_awvalid = 1'b1;
        s_wdata = 32'h0000_0099;
        s_wstrb = 4'h0;
        s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        #4;
        checks++;
        if (p_we !== 16'h0002 || p_sel !== 4'h0) begin
            errors++;
            $display("FAIL zstrb_commit: got we=%h sel=%h want 0002 0", p_we, p_sel);
        end
        tick();
        s_bready = 1'b1;
        #4;
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
            errors++;
            $display("FAIL zstrb_b: got v=%b r=%b want 1 00", s_bvalid, s_bresp);
        end
        tick();
        s_bready = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        s_awaddr = 32'h0000_0408;
        s_awvalid = 1'b1;
        s_araddr = 32'h0000_0100;
        s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_arvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_hs: got %b want 00000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        checks++;
        if ({p_we, p_rd, s_rdata, p_waddr} !== '0) begin
            errors++;
            $display("FAIL rstmid_data: got we=%h rd=%h rdata=%h waddr=%h want 0",
                     p_we, p_rd, s_rdata, p_waddr);
        end
        tick();
        tick();
        rst = 1'b0;
        we_cnt = 0;
        rd_cnt = 0;
        tick();
        s_wdata = 32'h0000_0077;
        s_wstrb = 4'hF;
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #4;
        checks++;
        if (we_cnt !== 0 || s_bvalid !== 1'b0 || s_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stray: got we=%0d bv=%b rv=%b want 0 0 0",
                     we_cnt, s_bvalid, s_rvalid);
        end
        tick();
        s_araddr = 32'h0000_0200;
        s_arvalid = 1'b1;
        #4;
        checks++;
        if (p_rd !== 16'h0004) begin
            errors++;
            $display("FAIL rstmid_rd: got %h want 0004", p_rd);
        end
        tick();
        s_arvalid = 1'b0;
        tick();
        s_rready = 1'b1;
        #4;
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hA000_0002 || s_rresp !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_read: got v=%b d=%h r=%b want 1 a0000002 00",
                     s_rvalid, s_rdata, s_rresp);
        end
        tick();
        s_rready = 1'b0;
        #4;
        checks++;
        if (s_rvalid !== 1'b0 || rd_cnt !== 1) begin
            errors++;
            $display("FAIL rstmid_done: got rv=%b rd=%0d want 0 1", s_rvalid, rd_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0;
        s_awvalid = 1'b0;
        s_wdata = '0;
        s_wstrb = '0;
        s_wvalid = 1'b0;
        s_bready = 1'b0;
        s_araddr = '0;
        s_arvalid = 1'b0;
        s_rready = 1'b0;
        for (int i = 0; i < 16; i++) p_rdata[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_aw_first();
        test_w_first_bstall();
        test_read_slot15();
        test_decerr();
        test_back_to_back();
        test_zero_strb();
        test_reset_mid();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
